fp_add_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined single-precision (IEEE-754 binary32) adder between NUM_REQ requesters. Each requester uses a valid/ready operand handshake. The block issues one operation per cycle to the adder, tracks in-flight requester IDs through a tag pipeline, and returns results in issue order through a response FIFO. Credit-based flow control means an issued result can never be dropped under response backpressure. The block sits between client engines and the shared FP adder datapath.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_rsp_fifo.sv | 43 ++++
 rtl/fp_add_scheduler.sv | 84 ++++++++
 tb/tb_fp_add_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 constants, field struct and ID-width helper for the FP add scheduler
package fp_pkg;
  localparam int FP_W = 32;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exponent;
    logic [MANT_W-1:0] mantissa;
  } fp32_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fp_rsp_fifo.sv
// fp_rsp_fifo: response FIFO (DEPTH x W) with registered head; ports clk/rst, wr/din push, rd pop, valid/dout head
module fp_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic         valid,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pop;
  logic [W-1:0] head_n;
  assign pop = rd && valid;
  assign rptr_n = rptr + AW'(pop);
  assign cnt_n = cnt + CW'(wr) - CW'(pop);
  // an entry written while nothing else remains bypasses storage into the head register
  assign head_n = (cnt - CW'(pop)) == '0 ? din : mem[rptr_n];
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      rptr <= rptr_n;
      cnt <= cnt_n;
      valid <= cnt_n != '0;
      if (cnt_n != '0) dout <= head_n;
    end
  assert property (@(posedge clk) disable iff (rst) !(wr && cnt == CW'(DEPTH)));
endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin, credit-controlled sharing of one pipelined FP adder; ports: req_* operand
// handshakes in, add_* to/from the adder, rsp_* in-order responses out
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [FP_W*NUM_REQ-1:0]     req_a,
  input  logic [FP_W*NUM_REQ-1:0]     req_b,
  output logic                        add_valid,
  output logic [FP_W-1:0]             add_a,
  output logic [FP_W-1:0]             add_b,
  input  logic [FP_W-1:0]             add_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]    rsp_id,
  output logic [FP_W-1:0]             rsp_result
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] credits;
  logic [ID_W-1:0] ptr, win, add_id;
  logic found, grant, pop;
  fp32_t op_a, op_b;
  logic [ADD_LAT-1:0] tag_v;
  logic [ID_W-1:0] tag_id [ADD_LAT];
  logic [ID_W+FP_W-1:0] rsp_data;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
  end
  // rst gates the grant so req_ready drops the instant reset asserts
  assign grant = !rst && found && credits != '0;
  assign req_ready = NUM_REQ'(grant) << win;
  assign pop = rsp_valid && rsp_ready;
  assign add_a = op_a;
  assign add_b = op_b;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      credits <= CW'(FIFO_DEPTH);
      ptr <= '0;
      add_valid <= 1'b0;
      add_id <= '0;
      op_a <= '0;
      op_b <= '0;
      tag_v <= '0;
    end else begin
      credits <= credits - CW'(grant) + CW'(pop);
      add_valid <= grant;
      if (grant) begin
        ptr <= win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
        add_id <= win;
        op_a <= req_a[FP_W*int'(win) +: FP_W];
        op_b <= req_b[FP_W*int'(win) +: FP_W];
      end
      tag_v[0] <= add_valid;
      for (int i = 1; i < ADD_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  always_ff @(posedge clk) begin
    tag_id[0] <= add_id;
    for (int i = 1; i < ADD_LAT; i++) tag_id[i] <= tag_id[i-1];
  end
  fp_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(ID_W + FP_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(tag_v[ADD_LAT-1]),
    .din({tag_id[ADD_LAT-1], add_result}),
    .rd(rsp_ready),
    .valid(rsp_valid),
    .dout(rsp_data)
  );
  assign {rsp_id, rsp_result} = rsp_data;
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: randomized and directed checks of the scheduler against a queue-based reference model
module tb_fp_add_scheduler;
  localparam int N = 4;
  localparam int L = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic add_valid;
  logic [31:0] add_a, add_b, add_result = '0, add_pipe = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic [31:0] rsp_result;
  typedef struct {
    int id;
    logic [31:0] res;
    int rdy;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, ptr_m = 0;
  bit pg = 0;
  logic [31:0] pa, pb;
  fp_add_scheduler #(.NUM_REQ(N), .ADD_LAT(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] i2f(input int unsigned n);
    int p;
    if (n == 0) return 32'h0;
    p = 31;
    while (!n[p]) p--;
    return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h7FFFFF)};
  endfunction
  function automatic int unsigned f2i(input logic [31:0] f);
    int p;
    if (f[30:0] == 0) return 0;
    p = int'(f[30:23]) - 127;
    return int'({8'h0, 1'b1, f[22:0]}) >> (23 - p);
  endfunction
  // behavioural adder, latency 2, exact for the integer-valued operands the bench drives
  always @(posedge clk) begin
    add_pipe <= add_valid ? i2f(f2i(add_a) + f2i(add_b)) : 32'hDEAD_BEEF ^ $urandom;
    add_result <= add_pipe;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 0);
    chk({tag, " add_valid"}, 64'(add_valid), 0);
    chk({tag, " add_a"}, 64'(add_a), 0);
    chk({tag, " add_b"}, 64'(add_b), 0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, " rsp_id"}, 64'(rsp_id), 0);
    chk({tag, " rsp_result"}, 64'(rsp_result), 0);
  endtask
  task automatic cycle(input logic [N-1:0] vm, input logic rr, input int fix);
    int w;
    bit ev;
    logic [N-1:0] er;
    int unsigned na[N], nb[N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      na[i] = fix >= 0 ? fix : $urandom_range(0, 1 << 20);
      nb[i] = fix >= 0 ? fix : $urandom_range(0, 1 << 20);
      req_a[32*i +: 32] = i2f(na[i]);
      req_b[32*i +: 32] = i2f(nb[i]);
    end
    req_valid = vm;
    rsp_ready = rr;
    #1;
    w = -1;
    if (q.size() < D)
      for (int k = 0; k < N; k++)
        if (w < 0 && vm[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    er = w >= 0 ? N'(1 << w) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("add_valid", 64'(add_valid), 64'(pg));
    if (pg) begin
      chk("add_a", 64'(add_a), 64'(pa));
      chk("add_b", 64'(add_b), 64'(pb));
    end
    ev = q.size() > 0 && q[0].rdy <= cyc;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
      if (rr) void'(q.pop_front());
    end
    pg = w >= 0;
    if (pg) begin
      pa = i2f(na[w]);
      pb = i2f(nb[w]);
      q.push_back('{w, i2f(na[w] + nb[w]), cyc + L + 2});
      ptr_m = (w + 1) % N;
    end
    cyc++;
  endtask
  initial begin
    req_valid = '1;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    cycle('0, 1, -1);
    cycle(4'b0001, 1, 1);
    repeat (6) cycle('0, 1, -1);
    repeat (16) cycle('1, 1, -1);
    repeat (8) cycle('0, 1, -1);
    repeat (8) cycle('1, 0, -1);
    cycle('1, 1, -1);
    repeat (4) cycle('1, 0, -1);
    repeat (10) cycle('0, 1, -1);
    repeat (3) cycle('1, 0, -1);
    repeat (4) cycle('0, 0, -1);
    cycle('1, 1, -1);
    repeat (4) cycle('1, 0, -1);
    repeat (10) cycle('0, 1, -1);
    repeat (12) cycle(4'b1010, 1, -1);
    repeat (300) cycle(N'($urandom), $urandom_range(0, 3) != 0, -1);
    repeat (10) cycle('0, 1, -1);
    cycle(4'b0001, 0, -1);
    repeat (4) cycle('0, 0, -1);
    repeat (2) cycle(4'b0110, 0, -1);
    @(negedge clk);
    req_valid = '1;
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    q.delete();
    ptr_m = 0;
    pg = 0;
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    repeat (L + 2) cycle('0, 1, -1);
    repeat (6) cycle('1, 0, -1);
    repeat (12) cycle('0, 1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
